// File: rtl/imem_dmem_port_arbiter_if.sv
// rtl/imem_dmem_port_arbiter_if.sv - fetch, load/store and memory-macro signals of the port arbiter
// Optional err lines exist only when ARB_MISALIGN_CHECK_EN is defined.
interface imem_dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ready;
  logic [DATA_W-1:0]     if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_ready;
  logic [DATA_W-1:0]     d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  core_stall;
`ifdef ARB_MISALIGN_CHECK_EN
  logic                  if_err;
  logic                  d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, mem_wstrb, core_stall, if_err, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, mem_wstrb, core_stall, if_err, d_err
  );
`else
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, mem_wstrb, core_stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr,
           mem_wdata, mem_wstrb, core_stall
  );
`endif
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// rtl/imem_dmem_port_arbiter.sv - shares one sync-read memory port between fetch and load/store
// Optional misaligned-address rejection is enabled by defining ARB_MISALIGN_CHECK_EN.
module imem_dmem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  imem_dmem_port_arbiter_if.slave bus
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              d_we_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [DATA_W-1:0] if_rdata_o, d_rdata_o;
  logic              grant_if, grant_d, issue;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_bad, resp_ok;
  logic              in_idle, in_busy_if, in_busy_d;

  assign in_idle    = (state_q == IDLE);
  assign in_busy_if = (state_q == BUSY_IF);
  assign in_busy_d  = (state_q == BUSY_D);

  // Data wins unless fetch has been starved for MAX_DATA_STREAK data grants.
  assign grant_d  = in_idle & bus.d_req & (~bus.if_req | (streak_q != STREAK_MAX));
  assign grant_if = in_idle & bus.if_req & ~grant_d;

  assign grant_addr = grant_d ? bus.d_addr : bus.if_addr;

`ifdef ARB_MISALIGN_CHECK_EN
  logic bad_q;

  assign grant_bad  = (grant_d | grant_if) & (grant_addr[1:0] != 2'b00);
  assign resp_ok    = ~bad_q;
  assign bus.if_err = in_busy_if & bad_q;
  assign bus.d_err  = in_busy_d & bad_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_q <= 1'b0;
    end else if (in_idle) begin
      bad_q <= grant_bad;
    end
  end
`else
  assign grant_bad = 1'b0;
  assign resp_ok   = 1'b1;
`endif

  // Reset gates the strobes combinationally so it takes hold before the next edge.
  assign issue         = (grant_d | grant_if) & ~grant_bad & ~reset;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & grant_d & bus.d_we;
  assign bus.mem_wstrb = bus.mem_we ? bus.d_wstrb : '0;
  assign bus.mem_addr  = grant_addr;
  assign bus.mem_wdata = bus.d_wdata;

  assign bus.if_ready = in_busy_if;
  assign bus.d_ready  = in_busy_d;

  assign if_rdata_o   = (in_busy_if & resp_ok) ? bus.mem_rdata : if_rdata_q;
  assign d_rdata_o    = (in_busy_d & resp_ok & ~d_we_q) ? bus.mem_rdata : d_rdata_q;
  assign bus.if_rdata = if_rdata_o;
  assign bus.d_rdata  = d_rdata_o;

  assign bus.core_stall = (bus.if_req & ~bus.if_ready) | (bus.d_req & ~bus.d_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
        end else if (grant_if) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF: state_d = IDLE;
      BUSY_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (grant_if) begin
      streak_d = '0;
    end else if (grant_d) begin
      if (!bus.if_req) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      d_we_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_o;
      d_rdata_q  <= d_rdata_o;
      if (grant_d) begin
        d_we_q <= bus.d_we;
      end
    end
  end
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb/tb_imem_dmem_port_arbiter.sv - scoreboard bench for imem_dmem_port_arbiter
// Directed vectors; a negedge monitor pops expected responses per requester.
module tb_imem_dmem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    byte kind;
    int  at;
  } log_t;

  exp_t        if_exp[$];
  exp_t        d_exp[$];
  log_t        log_q[$];
  logic [31:0] mem[64];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Synchronous-read memory model
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.if_ready) begin
        log_q.push_back('{8'h49, cyc});
        if (if_exp.size() == 0) begin
          chk("if_unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = if_exp.pop_front();
          chk("if_rdata", bus.if_rdata, e.rdata);
`ifdef ARB_MISALIGN_CHECK_EN
          chk("if_err", {31'd0, bus.if_err}, {31'd0, e.err});
`endif
        end
      end
      if (bus.d_ready) begin
        log_q.push_back('{8'h44, cyc});
        if (d_exp.size() == 0) begin
          chk("d_unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = d_exp.pop_front();
          chk("d_rdata", bus.d_rdata, e.rdata);
`ifdef ARB_MISALIGN_CHECK_EN
          chk("d_err", {31'd0, bus.d_err}, {31'd0, e.err});
`endif
        end
      end
    end
  end

  task automatic wait_if();
    bit got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.if_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("if_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_d();
    bit got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.d_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("d_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_hold(input logic [31:0] a, input logic [31:0] e);
    if_exp.push_back('{e, 1'b0});
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    wait_if();
  endtask

  task automatic data_hold(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic [31:0] e, input logic err);
    d_exp.push_back('{e, err});
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wstrb = st;
    bus.d_req   = 1'b1;
    wait_d();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    string       exp_kinds;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4]  = 32'h0000_0093;
    mem[5]  = 32'h0000_0013;
    mem[17] = 32'h1122_3344;
    mem[18] = 32'hA5A5_0001;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    bus.mem_rdata = 0;

    repeat (3) @(negedge clk);
    chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
`ifdef ARB_MISALIGN_CHECK_EN
    chk("rst_d_err", {31'd0, bus.d_err}, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch
    if_exp.push_back('{32'h0000_0093, 1'b0});
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("f1_mem_en", {31'd0, bus.mem_en}, 32'd1);
    chk("f1_mem_addr", bus.mem_addr, 32'h10);
    chk("f1_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("f1_stall_n", {31'd0, bus.core_stall}, 32'd1);
    @(negedge clk);
    chk("f1_if_ready", {31'd0, bus.if_ready}, 32'd1);
    chk("f1_stall_n1", {31'd0, bus.core_stall}, 32'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0;

    // Load, store (d_rdata holds), load back the stored word
    data_hold(1'b0, 32'h44, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
    bus.d_req = 1'b0;
    d_exp.push_back('{32'h1122_3344, 1'b0});
    bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
    bus.d_req = 1'b1;
    @(negedge clk);
    chk("st_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("st_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'hF);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_addr", bus.mem_addr, 32'h40);
    wait_d();
    bus.d_req = 1'b0;
    data_hold(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    bus.d_req = 1'b0;

    // Simultaneous requests, streak at 0
    log_q.delete();
    s = cyc;
    fork
      begin data_hold(1'b0, 32'h48, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0); bus.d_req = 1'b0; end
      begin fetch_hold(32'h14, 32'h0000_0013); bus.if_req = 1'b0; end
    join
    chk("sim_count", log_q.size(), 32'd2);
    if (log_q.size() >= 2) begin
      chk("sim_first_kind", {24'd0, log_q[0].kind}, 32'h44);
      chk("sim_d_cycle", log_q[0].at, s + 1);
      chk("sim_second_kind", {24'd0, log_q[1].kind}, 32'h49);
      chk("sim_if_cycle", log_q[1].at, s + 3);
    end

    // Both requesters held continuously
    log_q.delete();
    fork
      begin
        for (int i = 0; i < 5; i++)
          data_hold(1'b0, 32'h80 + 4 * i, 32'h0, 4'h0, 32'hC0DE_0020 + i, 1'b0);
        bus.d_req = 1'b0;
      end
      begin
        fetch_hold(32'h20, 32'hC0DE_0008);
        fetch_hold(32'h24, 32'hC0DE_0009);
        bus.if_req = 1'b0;
      end
    join
    exp_kinds = "DDDDIDI";
    chk("cont_count", log_q.size(), 32'd7);
    if (log_q.size() >= 7) begin
      for (int i = 0; i < 7; i++) chk("cont_kind", {24'd0, log_q[i].kind}, {24'd0, exp_kinds[i]});
      for (int i = 1; i < 7; i++) chk("cont_spacing", log_q[i].at - log_q[i-1].at, 32'd2);
    end

    // Reset while BUSY_D
    bus.d_we = 1'b0; bus.d_addr = 32'h48; bus.d_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rb_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("rb_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rb_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk("rb_if_rdata", bus.if_rdata, 32'd0);
    chk("rb_d_rdata", bus.d_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    data_hold(1'b0, 32'h48, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0);
    bus.d_req = 1'b0;

`ifdef ARB_MISALIGN_CHECK_EN
    d_exp.push_back('{32'hA5A5_0001, 1'b1});
    bus.d_we = 1'b0; bus.d_addr = 32'h42; bus.d_req = 1'b1;
    @(negedge clk);
    chk("mis_mem_en", {31'd0, bus.mem_en}, 32'd0);
    wait_d();
    bus.d_req = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("if_queue_drained", if_exp.size(), 32'd0);
    chk("d_queue_drained", d_exp.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
